// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: receiver byte handshake and command issue port.
// The slave modport is the decoder side; the master modport is the
// receiver/consumer side.
interface uart_cmd_decoder_if;
    logic        RX_DATA_READY;
    logic [7:0]  RX_DATA;
    logic        RX_DATA_RETRIEVED;
    logic [7:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        CMD_VALID;
    logic        CMD_ACK;

    modport slave (
        input  RX_DATA_READY,
        input  RX_DATA,
        input  CMD_ACK,
        output RX_DATA_RETRIEVED,
        output CMD_ADDR,
        output CMD_DATA,
        output CMD_VALID
    );

    modport master (
        output RX_DATA_READY,
        output RX_DATA,
        output CMD_ACK,
        input  RX_DATA_RETRIEVED,
        input  CMD_ADDR,
        input  CMD_DATA,
        input  CMD_VALID
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: frames UART bytes (sync, addr, data hi, data lo) into
// register commands with inter-byte timeout and a saturating error count.
// Optional macro CMD_CHECKSUM_EN adds a 5th XOR checksum byte per frame.
module uart_cmd_decoder #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TIMEOUT_WIDTH  = 17
) (
    input  logic              CLK,
    input  logic              RST,
    uart_cmd_decoder_if.slave bus,
    output logic              BUSY,
    output logic              ERROR,
    output logic [7:0]        ERR_COUNT
);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DHI   = 3'd2,
        S_DLO   = 3'd3,
`ifdef CMD_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_ISSUE = 3'd5
    } state_e;

    state_e                   state_q, state_d;
    logic                     rd_q, rd_d;
    logic [1:0]               guard_q, guard_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [7:0]               addr_sh_q, addr_sh_d;
    logic [15:0]              data_sh_q, data_sh_d;
    logic [7:0]               cmd_addr_q, cmd_addr_d;
    logic [15:0]              cmd_data_q, cmd_data_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic                     err_q, err_d;
    logic [7:0]               err_cnt_q, err_cnt_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
    logic                     csum_ok_c;
`endif

    logic rx_state_c;
    logic timing_c;
    logic accept_c;
    logic tmo_hit_c;

    // Accept qualification: receive state, byte present, not inside the post-pulse guard window.
    always_comb begin
        rx_state_c = 1'b0;
        case (state_q)
            S_IDLE, S_ADDR, S_DHI, S_DLO: rx_state_c = 1'b1;
`ifdef CMD_CHECKSUM_EN
            S_CSUM:                       rx_state_c = 1'b1;
`endif
            default:                      rx_state_c = 1'b0;
        endcase
        timing_c  = rx_state_c && (state_q != S_IDLE);
        accept_c  = bus.RX_DATA_READY && !rd_q && (guard_q == 2'b00) && rx_state_c;
        tmo_hit_c = timing_c && !accept_c && (tmo_q == TMO_LAST);
    end

`ifdef CMD_CHECKSUM_EN
    assign csum_ok_c = (bus.RX_DATA == csum_q);
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accept takes priority over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c && (bus.RX_DATA == SYNC_BYTE)) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (accept_c)       state_d = S_DHI;
                else if (tmo_hit_c) state_d = S_IDLE;
            end
            S_DHI: begin
                if (accept_c)       state_d = S_DLO;
                else if (tmo_hit_c) state_d = S_IDLE;
            end
            S_DLO: begin
`ifdef CMD_CHECKSUM_EN
                if (accept_c)       state_d = S_CSUM;
`else
                if (accept_c)       state_d = S_ISSUE;
`endif
                else if (tmo_hit_c) state_d = S_IDLE;
            end
`ifdef CMD_CHECKSUM_EN
            S_CSUM: begin
                if (accept_c)       state_d = csum_ok_c ? S_ISSUE : S_IDLE;
                else if (tmo_hit_c) state_d = S_IDLE;
            end
`endif
            S_ISSUE: begin
                if (bus.CMD_ACK) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        rd_d        = accept_c;
        guard_d     = {guard_q[0], rd_q};
        tmo_d       = tmo_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        err_d       = 1'b0;
`ifdef CMD_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (accept_c || tmo_hit_c) tmo_d = '0;
        else if (timing_c)         tmo_d = tmo_q + TIMEOUT_WIDTH'(1);

        if (tmo_hit_c) begin
            err_d     = 1'b1;
            addr_sh_d = '0;
            data_sh_d = '0;
`ifdef CMD_CHECKSUM_EN
            csum_d    = '0;
`endif
        end

        if (accept_c) begin
            case (state_q)
                S_ADDR: begin
                    addr_sh_d = bus.RX_DATA;
`ifdef CMD_CHECKSUM_EN
                    csum_d    = bus.RX_DATA;
`endif
                end
                S_DHI: begin
                    data_sh_d[15:8] = bus.RX_DATA;
`ifdef CMD_CHECKSUM_EN
                    csum_d          = csum_q ^ bus.RX_DATA;
`endif
                end
                S_DLO: begin
                    data_sh_d[7:0] = bus.RX_DATA;
`ifdef CMD_CHECKSUM_EN
                    csum_d         = csum_q ^ bus.RX_DATA;
`else
                    cmd_addr_d     = addr_sh_q;
                    cmd_data_d     = {data_sh_q[15:8], bus.RX_DATA};
                    cmd_valid_d    = 1'b1;
`endif
                end
`ifdef CMD_CHECKSUM_EN
                S_CSUM: begin
                    if (csum_ok_c) begin
                        cmd_addr_d  = addr_sh_q;
                        cmd_data_d  = data_sh_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        addr_sh_d = '0;
                        data_sh_d = '0;
                        csum_d    = '0;
                    end
                end
`endif
                default: ;
            endcase
        end

        if ((state_q == S_ISSUE) && bus.CMD_ACK) cmd_valid_d = 1'b0;

        err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_q        <= 1'b0;
            guard_q     <= 2'b00;
            tmo_q       <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`ifdef CMD_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            rd_q        <= rd_d;
            guard_q     <= guard_d;
            tmo_q       <= tmo_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef CMD_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.RX_DATA_RETRIEVED = rd_q;
    assign bus.CMD_ADDR          = cmd_addr_q;
    assign bus.CMD_DATA          = cmd_data_q;
    assign bus.CMD_VALID         = cmd_valid_q;
    assign BUSY                  = (state_q != S_IDLE);
    assign ERROR                 = err_q;
    assign ERR_COUNT             = err_cnt_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed bench for uart_cmd_decoder with a short
// timeout so timeout and saturation scenarios stay within a few thousand cycles.
module tb_uart_cmd_decoder;
    localparam int unsigned TMO = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BUSY;
    logic       ERROR;
    logic [7:0] ERR_COUNT;

    int n_checks   = 0;
    int n_pass     = 0;
    int n_fail     = 0;
    int rd_pulses  = 0;
    int err_pulses = 0;

    uart_cmd_decoder_if bus_if ();

    uart_cmd_decoder #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_WIDTH  (5)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus_if),
        .BUSY      (BUSY),
        .ERROR     (ERROR),
        .ERR_COUNT (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    // Pulse counters for byte-consume and error strobes.
    always @(posedge CLK) begin
        if (bus_if.RX_DATA_RETRIEVED === 1'b1) rd_pulses++;
        if (ERROR === 1'b1) err_pulses++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a byte, wait for its consume pulse, keep READY up 'hold' cycles after it.
    task automatic send_byte(input logic [7:0] b, input int hold);
        int n;
        bus_if.RX_DATA       = b;
        bus_if.RX_DATA_READY = 1'b1;
        n = 0;
        while (bus_if.RX_DATA_RETRIEVED !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("rx_pulse", {31'd0, bus_if.RX_DATA_RETRIEVED}, 32'd1);
        repeat (hold) tick();
        bus_if.RX_DATA_READY = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] a, input logic [15:0] d, input int hold);
        logic [7:0] cs;
        cs = a ^ d[15:8] ^ d[7:0];
        send_byte(a, hold);
        send_byte(d[15:8], hold);
        send_byte(d[7:0], hold);
`ifdef CMD_CHECKSUM_EN
        send_byte(cs, hold);
`else
        cs = 8'h00;
`endif
    endtask

    task automatic expect_cmd(input string tag, input logic [7:0] a, input logic [15:0] d);
        check({tag, "_valid"}, {31'd0, bus_if.CMD_VALID}, 32'd1);
        check({tag, "_busy"},  {31'd0, BUSY}, 32'd1);
        check({tag, "_addr"},  {24'd0, bus_if.CMD_ADDR}, {24'd0, a});
        check({tag, "_data"},  {16'd0, bus_if.CMD_DATA}, {16'd0, d});
    endtask

    task automatic ack_cmd(input string tag);
        bus_if.CMD_ACK = 1'b1;
        tick();
        bus_if.CMD_ACK = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, bus_if.CMD_VALID}, 32'd0);
        check({tag, "_idle"},       {31'd0, BUSY}, 32'd0);
    endtask

    localparam int FRAME_BYTES =
`ifdef CMD_CHECKSUM_EN
        5;
`else
        4;
`endif

    initial begin
        int rd0;
        int e0;
        int n;
        logic ok_all;
        logic [7:0] ec0;

        // Reset with a byte pending.
        bus_if.RX_DATA_READY = 1'b1;
        bus_if.RX_DATA       = 8'hA5;
        bus_if.CMD_ACK       = 1'b0;
        RST = 1'b0;
        repeat (5) tick();
        check("rst_retrieved", {31'd0, bus_if.RX_DATA_RETRIEVED}, 32'd0);
        check("rst_valid",     {31'd0, bus_if.CMD_VALID}, 32'd0);
        check("rst_addr",      {24'd0, bus_if.CMD_ADDR}, 32'd0);
        check("rst_data",      {16'd0, bus_if.CMD_DATA}, 32'd0);
        check("rst_busy",      {31'd0, BUSY}, 32'd0);
        check("rst_error",     {31'd0, ERROR}, 32'd0);
        check("rst_errcnt",    {24'd0, ERR_COUNT}, 32'd0);
        check("rst_no_pulse",  32'(rd_pulses), 32'd0);
        bus_if.RX_DATA_READY = 1'b0;
        RST = 1'b1;
        tick();

        // Nominal frame, ACK three cycles after VALID.
        rd0 = rd_pulses;
        send_byte(8'hA5, 1);
        check("nom_busy_after_sync", {31'd0, BUSY}, 32'd1);
        send_body(8'h12, 16'hBEEF, 1);
        check("nom_pulses", 32'(rd_pulses - rd0), 32'(FRAME_BYTES));
        expect_cmd("nom", 8'h12, 16'hBEEF);
        tick();
        tick();
        check("nom_valid_held", {31'd0, bus_if.CMD_VALID}, 32'd1);
        ack_cmd("nom");
        check("nom_addr_hold", {24'd0, bus_if.CMD_ADDR}, 32'h12);
        check("nom_data_hold", {16'd0, bus_if.CMD_DATA}, 32'hBEEF);
        check("nom_no_error", 32'(err_pulses), 32'd0);

        // READY held three cycles past each pulse: still one consume per byte.
        rd0 = rd_pulses;
        send_byte(8'hA5, 3);
        send_body(8'h34, 16'h5678, 3);
        check("guard_pulses", 32'(rd_pulses - rd0), 32'(FRAME_BYTES));
        expect_cmd("guard", 8'h34, 16'h5678);
        ack_cmd("guard");

        // Junk before sync is dropped silently.
        rd0 = rd_pulses;
        send_byte(8'h00, 1);
        check("junk0_idle", {31'd0, BUSY}, 32'd0);
        send_byte(8'hFF, 1);
        check("junk1_idle", {31'd0, BUSY}, 32'd0);
        check("junk_pulses", 32'(rd_pulses - rd0), 32'd2);
        send_byte(8'hA5, 1);
        send_body(8'h01, 16'h0005, 1);
        check("junk_no_error", 32'(err_pulses), 32'd0);
        expect_cmd("junk", 8'h01, 16'h0005);
        ack_cmd("junk");

        // Inter-byte timeout after sync + address.
        e0 = err_pulses;
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        n = 0;
        while (ERROR !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("tmo_latency", 32'(n), 32'd19);
        check("tmo_errcnt", {24'd0, ERR_COUNT}, 32'd1);
        check("tmo_idle", {31'd0, BUSY}, 32'd0);
        tick();
        check("tmo_error_one_cycle", {31'd0, ERROR}, 32'd0);
        check("tmo_err_pulses", 32'(err_pulses - e0), 32'd1);
        send_byte(8'hA5, 1);
        send_body(8'h77, 16'h0001, 1);
        expect_cmd("post_tmo", 8'h77, 16'h0001);
        ack_cmd("post_tmo");

        // Sync byte waiting while a command is held unacknowledged.
        send_byte(8'hA5, 1);
        send_body(8'h9A, 16'hBCDE, 1);
        expect_cmd("bp_first", 8'h9A, 16'hBCDE);
        rd0 = rd_pulses;
        bus_if.RX_DATA       = 8'hA5;
        bus_if.RX_DATA_READY = 1'b1;
        repeat (5) tick();
        check("bp_no_consume", 32'(rd_pulses - rd0), 32'd0);
        check("bp_valid_held", {31'd0, bus_if.CMD_VALID}, 32'd1);
        ack_cmd("bp_first");
        send_byte(8'hA5, 1);
        send_body(8'h11, 16'h2233, 1);
        check("bp_pulses", 32'(rd_pulses - rd0), 32'(FRAME_BYTES));
        expect_cmd("bp_second", 8'h11, 16'h2233);
        ack_cmd("bp_second");

`ifdef CMD_CHECKSUM_EN
        // Wrong checksum byte.
        e0  = err_pulses;
        ec0 = ERR_COUNT;
        send_byte(8'hA5, 1);
        send_byte(8'h12, 1);
        send_byte(8'hBE, 1);
        send_byte(8'hEF, 1);
        send_byte(8'h00, 1);
        check("csum_err_pulse", 32'(err_pulses - e0), 32'd1);
        check("csum_errcnt", {24'd0, ERR_COUNT}, {24'd0, ec0 + 8'd1});
        check("csum_no_valid", {31'd0, bus_if.CMD_VALID}, 32'd0);
        check("csum_idle", {31'd0, BUSY}, 32'd0);
`else
        ec0 = ERR_COUNT;
`endif

        // 300 timeouts: counter saturates at FF.
        e0 = err_pulses;
        ok_all = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5, 1);
            n = 0;
            while (ERROR !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            ok_all = ok_all & (ERROR === 1'b1);
            tick();
        end
        check("sat_all_errors", {31'd0, ok_all}, 32'd1);
        check("sat_err_pulses", 32'(err_pulses - e0), 32'd300);
        check("sat_errcnt", {24'd0, ERR_COUNT}, 32'hFF);
        check("sat_idle", {31'd0, BUSY}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Command sequencer between the UART receiver and the ASIC tester register bank. Consumes bytes through the receiver's DATA_READY/DATA_RETRIEVED handshake and frames them into commands: sync byte, address byte, 16-bit data (MSB first). Presents each command on a valid/ack port. Provides inter-byte timeout, error reporting and a saturating error counter.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker; any other byte in IDLE is discarded silently.
TIMEOUT_CYCLES, 100000, maximum CLK cycles allowed between bytes inside a frame (1 ms at 100 MHz, about 11.5 byte times at 115200 baud).
TIMEOUT_WIDTH, 17, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
CLK  input  1  system clock, 100 MHz.
RST  input  1  synchronous, active-low reset.
RX_DATA_READY  input  1  receiver holds a byte (receiver DATA_READY).
RX_DATA  input  8  received byte (receiver DATA).
RX_DATA_RETRIEVED  output  1  one-cycle pulse; byte consumed (to receiver DATA_RETRIEVED).
CMD_ADDR  output  8  command register address.
CMD_DATA  output  16  command write data.
CMD_VALID  output  1  command available; held until CMD_ACK.
CMD_ACK  input  1  consumer accepts the command this cycle.
BUSY  output  1  high in any state except S_IDLE.
ERROR  output  1  one-cycle pulse on timeout or checksum failure.
ERR_COUNT  output  8  saturating count of ERROR pulses.

Behaviour:
- Reset (RST==0 at a CLK edge): state S_IDLE. RX_DATA_RETRIEVED=0, CMD_ADDR=0, CMD_DATA=0, CMD_VALID=0, BUSY=0, ERROR=0, ERR_COUNT=0, timeout counter=0, guard flag=0. Reset mid-frame or mid-issue drops the partial or pending command.
- Byte accept:
  - A byte is accepted when RX_DATA_READY==1, guard==0, and the state is a receive state (S_IDLE, S_ADDR, S_DHI, S_DLO, S_CSUM).
  - On accept, RX_DATA is registered and RX_DATA_RETRIEVED is pulsed high for exactly one cycle, in the cycle after the accept decision.
  - guard is set for the 2 cycles following the pulse. The receiver needs one cycle to drop DATA_READY, so the same byte is never accepted twice.
- States:
  - S_IDLE: accepted byte == SYNC_BYTE -> S_ADDR; any other byte is consumed and dropped, state stays S_IDLE, no error.
  - S_ADDR: accepted byte -> CMD_ADDR shadow register; next S_DHI.
  - S_DHI: accepted byte -> data[15:8]; next S_DLO.
  - S_DLO: accepted byte -> data[7:0]; next S_ISSUE (or S_CSUM when the optional feature is compiled in).
  - S_ISSUE: CMD_ADDR and CMD_DATA are updated from the shadow registers on entry. CMD_VALID=1 from the entry cycle until the cycle CMD_ACK==1 is sampled. The following cycle CMD_VALID=0 and state is S_IDLE. No bytes are accepted in S_ISSUE; the receiver holds its byte, DATA_READY stays high, and that byte is accepted from S_IDLE.
- CMD_ACK outside S_ISSUE is ignored. CMD_ADDR and CMD_DATA hold their last values after issue.
- Timeout:
  - The counter clears on every accept and on entry to S_ADDR, and increments each cycle in S_ADDR, S_DHI, S_DLO and S_CSUM.
  - When the counter reaches TIMEOUT_CYCLES-1: ERROR pulses for 1 cycle, ERR_COUNT increments, state -> S_IDLE, shadow registers are discarded.
  - If an accept and the timeout fall in the same cycle, the accept wins.
  - The counter is frozen in S_IDLE and S_ISSUE; a slow consumer never causes a timeout.
- ERR_COUNT saturates at 8'hFF and does not wrap.
- BUSY is combinational from the state.

Optional Feature:
Macro CMD_CHECKSUM_EN.
- Defined:
  - The frame gains a 5th byte: the XOR of the address, data-high and data-low bytes. SYNC_BYTE is not included in the XOR.
  - S_DLO goes to S_CSUM. An accepted byte equal to the running XOR -> S_ISSUE.
  - On mismatch: ERROR pulse, ERR_COUNT+1, state -> S_IDLE, no CMD_VALID.
  - The S_CSUM timeout rule is the same as in the other receive states.
- Undefined: S_CSUM and the XOR register are not present; S_DLO goes straight to S_ISSUE.

Test Plan:
- Reset behaviour: hold RST=0 for 5 cycles with RX_DATA_READY=1 -> all outputs 0, no RX_DATA_RETRIEVED pulse.
- Nominal frame: bytes A5,12,BE,EF (plus checksum 43 with CMD_CHECKSUM_EN) with ACK 3 cycles after CMD_VALID -> exactly 4 (5) RX_DATA_RETRIEVED pulses. CMD_ADDR=12 and CMD_DATA=BEEF while CMD_VALID=1. CMD_VALID drops 1 cycle after ACK. ERROR never pulses.
- Handshake guard: RX_DATA_READY falls 1 cycle after each RX_DATA_RETRIEVED -> exactly one pulse per byte; a DATA_READY held high for 2 cycles is not double-consumed.
- Junk before sync: bytes 00,FF,A5,01,00,05 -> two dropped bytes with no ERROR, then command addr 01 data 0005.
- Timeout: A5,01 then silence for TIMEOUT_CYCLES cycles -> one ERROR pulse, ERR_COUNT=1, BUSY=0. A subsequent full frame decodes correctly.
- Back-pressure and saturation:
  - Next frame's sync byte arrives while CMD_VALID is held unacked -> byte consumed only after ACK, next command decodes.
  - Force 300 timeouts -> ERR_COUNT stays 8'hFF.
  - With CMD_CHECKSUM_EN, a bad checksum byte 00 -> ERROR pulse and no CMD_VALID.
